// File: rtl/chacha_pkg.sv
// Shared ChaCha definitions: word type, rotation amounts, quarter-round
// index groups and the round-engine FSM encoding.
package chacha_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam int unsigned ROT_A = 16;
  localparam int unsigned ROT_B = 12;
  localparam int unsigned ROT_C = 8;
  localparam int unsigned ROT_D = 7;

  // Word indices (a,b,c,d) of the four parallel quarter rounds.
  localparam logic [3:0] COL_IDX [4][4] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15}
  };

  localparam logic [3:0] DIAG_IDX [4][4] = '{
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

  function automatic word_t ror(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

endpackage

// File: rtl/chacha_inv_quarterround.sv
// Combinational inverse ChaCha quarter round: undoes the forward steps in
// reverse order (rotate right, xor, then subtract).
module chacha_inv_quarterround
  import chacha_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  output word_t a_res,
  output word_t b_res,
  output word_t c_res,
  output word_t d_res
);

  word_t a1, b1, c1, d1, b2, d2;

  assign b1    = ror(b, ROT_D) ^ c;
  assign c1    = c - d;
  assign d1    = ror(d, ROT_C) ^ a;
  assign a1    = a - b1;
  assign b2    = ror(b1, ROT_B) ^ c1;
  assign c_res = c1 - d1;
  assign d2    = ror(d1, ROT_A) ^ a1;
  assign a_res = a1 - b2;
  assign b_res = b2;
  assign d_res = d2;

endmodule

// File: rtl/chacha_inv_rounds.sv
// Iterative inverse ChaCha core: recovers the pre-round state from the
// post-round state, one inverse half-round per clock.
module chacha_inv_rounds
  import chacha_pkg::*;
#(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_state
);

  localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  fsm_t          fsm_reg, fsm_next;
  logic [CW-1:0] cnt_reg;
  word_t         words_reg   [16];
  word_t         round_words [16];
  word_t         q_in        [4][4];
  word_t         q_out       [4][4];
  logic          odd_round;
  logic          last_round;
  logic          accept;

  // Forward rounds end on a diagonal round, so inversion starts with diagonals.
  assign odd_round  = cnt_reg[0];
  assign last_round = (cnt_reg == CW'(ROUNDS - 1));
  assign accept     = in_valid && in_ready;

  for (genvar gi = 0; gi < 4; gi++) begin : g_qr
    for (genvar gj = 0; gj < 4; gj++) begin : g_sel
      assign q_in[gi][gj] = odd_round ? words_reg[COL_IDX[gi][gj]]
                                      : words_reg[DIAG_IDX[gi][gj]];
    end

    chacha_inv_quarterround u_qr (
      .a     (q_in[gi][0]),
      .b     (q_in[gi][1]),
      .c     (q_in[gi][2]),
      .d     (q_in[gi][3]),
      .a_res (q_out[gi][0]),
      .b_res (q_out[gi][1]),
      .c_res (q_out[gi][2]),
      .d_res (q_out[gi][3])
    );
  end

  always_comb begin
    round_words = words_reg;
    for (int g = 0; g < 4; g++) begin
      for (int p = 0; p < 4; p++) begin
        if (odd_round) round_words[COL_IDX[g][p]]  = q_out[g][p];
        else           round_words[DIAG_IDX[g][p]] = q_out[g][p];
      end
    end
  end

  always_comb begin
    fsm_next  = fsm_reg;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (fsm_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_next = RUN;
      end
      RUN: begin
        if (last_round) fsm_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg <= IDLE;
      cnt_reg <= '0;
      for (int k = 0; k < 16; k++) words_reg[k] <= '0;
    end else begin
      fsm_reg <= fsm_next;
      if (accept) begin
        cnt_reg <= '0;
        for (int k = 0; k < 16; k++) words_reg[k] <= in_state[32*k +: 32];
      end else if (fsm_reg == RUN) begin
        words_reg <= round_words;
        if (!last_round) cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_out
    assign out_state[32*gi +: 32] = words_reg[gi];
  end

endmodule

// File: tb/tb_chacha_inv_rounds.sv
// Scoreboard bench: forward ChaCha model builds inputs, a monitor checks
// recovered states and latency for ROUNDS = 20, 8 and 12.
module tb_chacha_inv_rounds;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [511:0] in_state  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [511:0] out_state [3];

  logic [31:0] qa, qb, qc, qd, ra, rb, rc, rd;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [511:0] exp_q [3][$];
  int           acc_q [3][$];
  bit           seen  [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    chacha_inv_rounds #(.ROUNDS(gi == 0 ? 20 : (gi == 1 ? 8 : 12))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready[gi]),
      .in_state  (in_state[gi]),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready[gi]),
      .out_state (out_state[gi])
    );
  end

  chacha_inv_quarterround u_qr (
    .a     (qa),
    .b     (qb),
    .c     (qc),
    .d     (qd),
    .a_res (ra),
    .b_res (rb),
    .c_res (rc),
    .d_res (rd)
  );

  function automatic int rounds_of(input int i);
    return (i == 0) ? 20 : ((i == 1) ? 8 : 12);
  endfunction

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Forward quarter round straight from the ChaCha definition.
  function automatic logic [127:0] fqr(input logic [31:0] a0, b0, c0, d0);
    logic [31:0] a, b, c, d;
    a = a0; b = b0; c = c0; d = d0;
    a = a + b; d = rol(d ^ a, 16);
    c = c + d; b = rol(b ^ c, 12);
    a = a + b; d = rol(d ^ a, 8);
    c = c + d; b = rol(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  // Forward rounds: even rounds are columns, odd rounds are diagonals.
  function automatic logic [511:0] fwd(input logic [511:0] s, input int r);
    logic [31:0]  w [16];
    logic [127:0] t;
    logic [511:0] res;
    int i0, i1, i2, i3;
    for (int k = 0; k < 16; k++) w[k] = s[32*k +: 32];
    for (int n = 0; n < r; n++) begin
      for (int g = 0; g < 4; g++) begin
        i0 = g;
        if (n % 2 == 0) begin
          i1 = g + 4; i2 = g + 8; i3 = g + 12;
        end else begin
          i1 = 4 + (g + 1) % 4; i2 = 8 + (g + 2) % 4; i3 = 12 + (g + 3) % 4;
        end
        t = fqr(w[i0], w[i1], w[i2], w[i3]);
        w[i0] = t[127:96]; w[i1] = t[95:64]; w[i2] = t[63:32]; w[i3] = t[31:0];
      end
    end
    for (int k = 0; k < 16; k++) res[32*k +: 32] = w[k];
    return res;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, expv);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  task automatic send(input int i, input logic [511:0] data, input logic [511:0] expv);
    int n = 0;
    in_valid[i] = 1'b1;
    in_state[i] = data;
    while (!in_ready[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[i]) begin
      fail("accept_timeout");
      in_valid[i] = 1'b0;
      return;
    end
    exp_q[i].push_back(expv);
    acc_q[i].push_back(cyc + 1);
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
    in_state[i] = rnd512();
  endtask

  task automatic wait_done(input int i);
    int n = 0;
    while ((exp_q[i].size() != 0 || out_valid[i]) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) fail("done_timeout");
  endtask

  // Monitor: the first cycle of each out_valid window is one transaction.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_n && out_valid[i] && !seen[i]) begin
        seen[i] = 1'b1;
        if (exp_q[i].size() == 0) begin
          fail("unexpected_output");
        end else begin
          logic [511:0] e;
          int a;
          e = exp_q[i].pop_front();
          a = acc_q[i].pop_front();
          chk("out_state", out_state[i], e);
          chk("latency", 512'(cyc - a), 512'(rounds_of(i)));
          $display("txn inst=%0d rounds=%0d latency=%0d state_word0=%h", i, rounds_of(i),
                   cyc - a, out_state[i][31:0]);
        end
      end
      if (!out_valid[i]) seen[i] = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] rfc, x;
    rfc = {32'h00000000, 32'h4a000000, 32'h09000000, 32'h00000001,
           32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
           32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
           32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      in_state[i]  = '0;
      out_ready[i] = 1'b1;
      seen[i]      = 1'b0;
    end

    qa = 32'hea2a92f4; qb = 32'hcb1cf8ce; qc = 32'h4581472e; qd = 32'h5881c4bb;
    #1;
    chk("qr_a", 512'(ra), 512'(32'h11111111));
    chk("qr_b", 512'(rb), 512'(32'h01020304));
    chk("qr_c", 512'(rc), 512'(32'h9b8d6f43));
    chk("qr_d", 512'(rd), 512'(32'h01234567));

    chk("rst_in_ready", 512'(in_ready[0]), 512'(1));
    chk("rst_out_valid", 512'(out_valid[0]), 512'(0));
    chk("rst_out_state", out_state[0], '0);

    // Accept on the very first edge after reset release.
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(0, '0, '0);
    wait_done(0);

    for (int i = 0; i < 3; i++) begin
      send(i, fwd(rfc, rounds_of(i)), rfc);
      wait_done(i);
      for (int k = 0; k < 3; k++) begin
        x = rnd512();
        send(i, fwd(x, rounds_of(i)), x);
      end
      wait_done(i);
    end

    // Backpressure with ignored in_valid pulses during RUN and DONE.
    out_ready[0] = 1'b0;
    x = rnd512();
    send(0, fwd(x, 20), x);
    for (int n = 0; n < 100 && !out_valid[0]; n++) begin
      chk("bp_run_in_ready", 512'(in_ready[0]), 512'(0));
      in_valid[0] = 1'($urandom_range(0, 1));
      in_state[0] = rnd512();
      @(negedge clk);
    end
    if (!out_valid[0]) fail("bp_out_valid_timeout");
    for (int n = 0; n < 5; n++) begin
      chk("bp_out_valid", 512'(out_valid[0]), 512'(1));
      chk("bp_out_state", out_state[0], x);
      chk("bp_in_ready", 512'(in_ready[0]), 512'(0));
      in_valid[0] = 1'($urandom_range(0, 1));
      in_state[0] = rnd512();
      @(negedge clk);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", 512'(out_valid[0]), 512'(0));
    chk("bp_release_in_ready", 512'(in_ready[0]), 512'(1));
    wait_done(0);

    // Reset in the middle of a run discards the transaction.
    x = rnd512();
    send(0, fwd(x, 20), x);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 512'(in_ready[0]), 512'(1));
    chk("midrst_out_valid", 512'(out_valid[0]), 512'(0));
    chk("midrst_out_state", out_state[0], '0);
    exp_q[0].delete();
    acc_q[0].delete();
    @(negedge clk);
    rst_n = 1'b1;
    x = rnd512();
    send(0, fwd(x, 20), x);
    wait_done(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
